// File: rtl/axi_lite_cfg_master.sv
// axi_lite_cfg_master
// Host-side AXI4-Lite master. Turns one valid/ready command into a single
// AXI4-Lite write (AW+W, then B) or read (AR, then R) and returns the result
// on a valid/ready response port. Only one transaction is in flight at a time.
// A wait counter flags transactions that stall for TIMEOUT_CYCLES cycles. The
// flag is reported with the response, and the AXI handshake is never aborted.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake (cmd_write, cmd_addr, cmd_wdata, cmd_wstrb)
//   rsp_valid/ready     response handshake (rsp_rdata, rsp_resp, rsp_timeout)
//   busy                high whenever the FSM is not idle
//   m_axi_aw*/w*/b*     AXI4-Lite write address, write data and write response channels
//   m_axi_ar*/r*        AXI4-Lite read address and read data channels
//
// State | Meaning
// ------+------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// WADDR | awvalid/wvalid up, each drops after its handshake
// WRESP | bready high, waiting for bvalid
// RADDR | arvalid up, waiting for arready
// RDATA | rready high, waiting for rvalid
// RESP  | rsp_valid high, outputs frozen until rsp_ready

module axi_lite_cfg_master #(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,

   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                  rsp_resp,
   output logic                        rsp_timeout,

   output logic                        busy,

   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                  m_axi_awprot,

   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,

   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   input  logic [1:0]                  m_axi_bresp,

   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                  m_axi_arprot,

   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp
);

   localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WRESP,
      RADDR,
      RDATA,
      RESP
   } state_t;

   state_t                    state;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [CNT_W-1:0]          wait_cnt;
   logic                      waiting;
   logic                      aw_done;
   logic                      w_done;

   assign cmd_ready    = (state == IDLE) && rst_n;
   assign busy         = (state != IDLE);
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;

   assign waiting = (state == WADDR) || (state == WRESP) ||
                    (state == RADDR) || (state == RDATA);

   // A channel is finished once its valid has dropped, or it handshakes this cycle.
   assign aw_done = !m_axi_awvalid || m_axi_awready;
   assign w_done  = !m_axi_wvalid  || m_axi_wready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         addr_q        <= '0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         rsp_timeout   <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         // The down-counter stops at zero, so it saturates on its own. Loading
         // zero (timeout disabled) means the terminal count is never reached.
         if (waiting && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_ONE;
            if (wait_cnt == CNT_ONE) begin
               rsp_timeout <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q      <= cmd_addr;
                  m_axi_wdata <= cmd_wdata;
                  m_axi_wstrb <= cmd_wstrb;
                  wait_cnt    <= CNT_LOAD;
                  rsp_timeout <= 1'b0;
                  if (cmd_write) begin
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= WADDR;
                  end else begin
                     m_axi_arvalid <= 1'b1;
                     state         <= RADDR;
                  end
               end
            end

            WADDR: begin
               if (m_axi_awready) begin
                  m_axi_awvalid <= 1'b0;
               end
               if (m_axi_wready) begin
                  m_axi_wvalid <= 1'b0;
               end
               if (aw_done && w_done) begin
                  m_axi_bready <= 1'b1;
                  state        <= WRESP;
               end
            end

            WRESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  rsp_resp     <= m_axi_bresp;
                  rsp_rdata    <= '0;
                  rsp_valid    <= 1'b1;
                  state        <= RESP;
               end
            end

            RADDR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= RDATA;
               end
            end

            RDATA: begin
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  rsp_rdata    <= m_axi_rdata;
                  rsp_resp     <= m_axi_rresp;
                  rsp_valid    <= 1'b1;
                  state        <= RESP;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
`timescale 1ns/1ps
module tb_axi_lite_cfg_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0]   cmd_addr;
   logic [DW-1:0]   cmd_wdata;
   logic [DW/8-1:0] cmd_wstrb;
   logic            rsp_valid, rsp_ready, rsp_timeout, busy;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic            m_axi_awvalid, m_axi_awready;
   logic [AW-1:0]   m_axi_awaddr;
   logic [2:0]      m_axi_awprot;
   logic            m_axi_wvalid, m_axi_wready;
   logic [DW-1:0]   m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic            m_axi_bvalid, m_axi_bready;
   logic [1:0]      m_axi_bresp;
   logic            m_axi_arvalid, m_axi_arready;
   logic [AW-1:0]   m_axi_araddr;
   logic [2:0]      m_axi_arprot;
   logic            m_axi_rvalid, m_axi_rready;
   logic [DW-1:0]   m_axi_rdata;
   logic [1:0]      m_axi_rresp;

   axi_lite_cfg_master #(
      .AXI_DATA_WIDTH(DW),
      .AXI_ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;

   // One command plus slave behaviour and the expected response.
   // dly_a: cycles aw/arvalid waits for its ready; dly_w: same for wvalid;
   // dly_r: cycles bready/rready waits for bvalid/rvalid; hold: rsp_ready low cycles.
   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          dly_a;
      int          dly_w;
      int          dly_r;
      logic [1:0]  resp;
      logic [31:0] sdata;
      int          hold;
      logic [31:0] exp_rdata;
      bit          exp_to;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] ws, input int da, input int dw, input int dr,
                               input logic [1:0] rs, input logic [31:0] sd, input int hold,
                               input logic [31:0] er, input bit eto, input int elat);
      vec_t v;
      v.write = w; v.addr = a; v.wdata = wd; v.wstrb = ws;
      v.dly_a = da; v.dly_w = dw; v.dly_r = dr;
      v.resp = rs; v.sdata = sd; v.hold = hold;
      v.exp_rdata = er; v.exp_to = eto; v.exp_lat = elat;
      return v;
   endfunction

   // Reference model: every wait state lasts one cycle plus the slave's delay;
   // the write address phase ends when the slower of AW and W has handshaken.
   function automatic vec_t rand_vec();
      vec_t v;
      int   wait_cycles;
      v.write = 1'($urandom_range(0, 1));
      v.addr  = $urandom & 32'hFFFF_FFFC;
      v.wdata = $urandom;
      v.wstrb = 4'($urandom_range(0, 15));
      v.dly_a = int'($urandom_range(0, 6));
      v.dly_w = v.write ? int'($urandom_range(0, 6)) : 0;
      v.dly_r = int'($urandom_range(0, 6));
      v.resp  = 2'($urandom_range(0, 3));
      v.sdata = $urandom;
      v.hold  = int'($urandom_range(0, 2));
      if (v.write)
         wait_cycles = 2 + ((v.dly_a > v.dly_w) ? v.dly_a : v.dly_w) + v.dly_r;
      else
         wait_cycles = 2 + v.dly_a + v.dly_r;
      v.exp_lat   = wait_cycles + 1;
      v.exp_to    = (wait_cycles >= TO);
      v.exp_rdata = v.write ? 32'h0 : v.sdata;
      return v;
   endfunction

   task automatic slave_idle();
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = $urandom;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_txn(input vec_t v);
      int cyc = 0;
      int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
      bit done = 0;
      bit aw_pend = 0, w_pend = 0, ar_pend = 0;
      bit aw_hs = 0, w_hs = 0, ar_hs = 0;
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
      cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
      @(posedge clk);
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
         if (cyc == 1) begin
            check("awvalid_rise", m_axi_awvalid, v.write);
            check("wvalid_rise", m_axi_wvalid, v.write);
            check("arvalid_rise", m_axi_arvalid, !v.write);
         end
         if (aw_pend) check("awvalid_held", m_axi_awvalid, 1);
         if (w_pend)  check("wvalid_held", m_axi_wvalid, 1);
         if (ar_pend) check("arvalid_held", m_axi_arvalid, 1);
         if (aw_hs)   check("awvalid_drop", m_axi_awvalid, 0);
         if (w_hs)    check("wvalid_drop", m_axi_wvalid, 0);
         if (ar_hs)   check("arvalid_drop", m_axi_arvalid, 0);
         if (m_axi_awvalid) check("awaddr", m_axi_awaddr, v.addr);
         if (m_axi_wvalid) begin
            check("wdata", m_axi_wdata, v.wdata);
            check("wstrb", m_axi_wstrb, v.wstrb);
         end
         if (m_axi_arvalid) check("araddr", m_axi_araddr, v.addr);
         if (m_axi_awvalid || m_axi_wvalid) check("bready_early", m_axi_bready, 0);
         if (m_axi_arvalid) check("rready_early", m_axi_rready, 0);
         if (v.write) check("rready_in_write", m_axi_rready, 0);
         else         check("bready_in_read", m_axi_bready, 0);
         check("busy_txn", busy, 1);
         check("cmd_ready_txn", cmd_ready, 0);
         if (rsp_valid) begin
            done = 1;
            slave_idle();
         end else begin
            m_axi_awready = m_axi_awvalid && (aw_cnt >= v.dly_a);
            m_axi_wready  = m_axi_wvalid  && (w_cnt  >= v.dly_w);
            m_axi_bvalid  = m_axi_bready  && (b_cnt  >= v.dly_r);
            m_axi_arready = m_axi_arvalid && (ar_cnt >= v.dly_a);
            m_axi_rvalid  = m_axi_rready  && (r_cnt  >= v.dly_r);
            m_axi_bresp   = m_axi_bvalid ? v.resp : 2'($urandom);
            m_axi_rresp   = m_axi_rvalid ? v.resp : 2'($urandom);
            m_axi_rdata   = m_axi_rvalid ? v.sdata : $urandom;
            aw_pend = m_axi_awvalid && !m_axi_awready;
            w_pend  = m_axi_wvalid  && !m_axi_wready;
            ar_pend = m_axi_arvalid && !m_axi_arready;
            aw_hs   = m_axi_awvalid && m_axi_awready;
            w_hs    = m_axi_wvalid  && m_axi_wready;
            ar_hs   = m_axi_arvalid && m_axi_arready;
            if (m_axi_awvalid) aw_cnt++;
            if (m_axi_wvalid)  w_cnt++;
            if (m_axi_bready)  b_cnt++;
            if (m_axi_arvalid) ar_cnt++;
            if (m_axi_rready)  r_cnt++;
         end
      end
      slave_idle();
      check("rsp_arrived", done, 1);
      if (done) begin
         check("rsp_latency", cyc, v.exp_lat);
         check("rsp_rdata", rsp_rdata, v.exp_rdata);
         check("rsp_resp", rsp_resp, v.resp);
         check("rsp_timeout", rsp_timeout, v.exp_to);
         for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, v.exp_rdata);
            check("hold_rsp_resp", rsp_resp, v.resp);
            check("hold_rsp_timeout", rsp_timeout, v.exp_to);
            check("hold_cmd_ready", cmd_ready, 0);
         end
         rsp_ready = 1'b1;
         @(negedge clk);
         rsp_ready = 1'b0;
         check("rsp_valid_drop", rsp_valid, 0);
         check("cmd_ready_after_rsp", cmd_ready, 1);
         check("busy_after_rsp", busy, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[8];
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
      slave_idle();
      repeat (3) @(negedge clk);

      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_awvalid", m_axi_awvalid, 0);
      check("rst_wvalid", m_axi_wvalid, 0);
      check("rst_bready", m_axi_bready, 0);
      check("rst_arvalid", m_axi_arvalid, 0);
      check("rst_rready", m_axi_rready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_resp", rsp_resp, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_awaddr", m_axi_awaddr, 0);
      check("rst_wdata", m_axi_wdata, 0);
      check("awprot", m_axi_awprot, 0);
      check("arprot", m_axi_arprot, 0);

      rst_n = 1'b1;
      #1;
      check("cmd_ready_first", cmd_ready, 1);
      @(negedge clk);

      //          wr  addr          wdata         strb  da dw dr resp   sdata         hold exp_rdata     to lat
      tbl[0] = mk(1, 32'h0000_0000, 32'h0000_0001, 4'hF, 0, 0, 0, 2'b00, 32'h0,         0, 32'h0,         0, 3);
      tbl[1] = mk(1, 32'h0000_0004, 32'h1111_2222, 4'hF, 0, 4, 0, 2'b00, 32'h0,         0, 32'h0,         0, 7);
      tbl[2] = mk(0, 32'h0000_0004, 32'h0,         4'h0, 0, 0, 5, 2'b10, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 8);
      tbl[3] = mk(0, 32'h0000_0008, 32'h0,         4'h0, 20, 0, 0, 2'b00, 32'h1234_5678, 0, 32'h1234_5678, 1, 23);
      tbl[4] = mk(1, 32'h0000_000C, 32'hA5A5_0000, 4'hC, 1, 1, 2, 2'b11, 32'h0,         0, 32'h0,         0, 6);
      tbl[5] = mk(0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 2'b01, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 0, 3);
      tbl[6] = mk(1, 32'h0000_0014, 32'h0BAD_0BAD, 4'h3, 3, 0, 3, 2'b00, 32'h0,         1, 32'h0,         1, 9);
      tbl[7] = mk(1, 32'h0000_0018, 32'h7777_0001, 4'h1, 0, 2, 3, 2'b01, 32'h0,         0, 32'h0,         0, 8);

      for (int i = 0; i < 8; i++) run_txn(tbl[i]);

      // Reset while the write address phase is stalled.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20;
      cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("midrst_awvalid_pre", m_axi_awvalid, 1);
      check("midrst_wvalid_pre", m_axi_wvalid, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_awvalid", m_axi_awvalid, 0);
      check("midrst_wvalid", m_axi_wvalid, 0);
      check("midrst_arvalid", m_axi_arvalid, 0);
      check("midrst_bready", m_axi_bready, 0);
      check("midrst_rready", m_axi_rready, 0);
      check("midrst_busy", busy, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_cmd_ready", cmd_ready, 1);
      check("midrst_rsp_valid_after", rsp_valid, 0);
      run_txn(tbl[0]);

      for (int i = 0; i < 40; i++) run_txn(rand_vec());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/axi_lite_cfg_master.md
# axi_lite_cfg_master

Host-side AXI4-Lite master that converts a simple valid/ready command port into single AXI4-Lite write or read transactions. It drives the configuration register file's AXI4-Lite slave port: the bench stimulus layer and the future on-chip sequencer use it to program the upscaler registers and to poll status. One transaction is outstanding at a time. The block records a per-transaction timeout without breaking AXI handshake rules.

## Interface
- AXI_DATA_WIDTH, 32, data width of the W and R channels and of the command/response data.
- AXI_ADDR_WIDTH, 32, width of the AW/AR address.
- TIMEOUT_CYCLES, 1024, number of wait cycles before the response's timeout bit is set; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDR_WIDTH  register byte address.
- cmd_wdata  in  AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  AXI_DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- rsp_timeout  out  1  set when the transaction exceeded TIMEOUT_CYCLES.
- busy  out  1  high in any state other than IDLE.
- m_axi_awvalid/awready, m_axi_awaddr[AXI_ADDR_WIDTH], m_axi_awprot[3]  out/in/out/out  standard AW channel.
- m_axi_wvalid/wready, m_axi_wdata[AXI_DATA_WIDTH], m_axi_wstrb[AXI_DATA_WIDTH/8]  out/in/out/out  standard W channel.
- m_axi_bvalid/bready, m_axi_bresp[2]  in/out/in  standard B channel.
- m_axi_arvalid/arready, m_axi_araddr[AXI_ADDR_WIDTH], m_axi_arprot[3]  out/in/out/out  standard AR channel.
- m_axi_rvalid/rready, m_axi_rdata[AXI_DATA_WIDTH], m_axi_rresp[2]  in/out/in/in  standard R channel.

## Operation
- States:
  - IDLE: accept a command.
  - WADDR: AW and W pending.
  - WRESP: wait for B.
  - RADDR: wait for AR acceptance.
  - RDATA: wait for R.
  - RESP: present the response.
- cmd_ready = (state==IDLE) && rst_n.
- On command acceptance:
  - Latch addr, wdata and wstrb.
  - Go to WADDR for a write, RADDR for a read.
  - Clear the wait counter and the timeout flag.
- WADDR:
  - awvalid and wvalid are registered and rise together.
  - Each valid drops independently, on the cycle after its own handshake.
  - Move to WRESP once both handshakes are complete (same cycle or different cycles).
- WRESP:
  - bready = 1.
  - On bvalid: capture bresp, set rdata to 0, go to RESP.
- RADDR:
  - arvalid held until arready, then go to RDATA.
- RDATA:
  - rready = 1.
  - On rvalid: capture rdata and rresp, go to RESP.
- RESP:
  - rsp_valid = 1; outputs held stable until rsp_ready, then return to IDLE.
- awprot and arprot are tied to 3'b000.
- Valid signals are never withdrawn before their handshake completes (AXI compliant).
- Timeout (wait counter):
  - Counts cycles in WADDR, WRESP, RADDR and RDATA, and saturates.
  - When the count reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), the timeout flag sets.
  - The transaction keeps waiting after the flag sets.
  - rsp_timeout reports the flag with the response.
- A non-OKAY resp is passed through unchanged; the block does not retry.

## Timing
- Reset values: all valid/ready outputs, rsp_*, busy and address/data outputs are 0; state is IDLE.
- cmd_ready is 1 on the first cycle with rst_n high.
- Minimum write latency, with awready, wready and bvalid all 1:
  - Accept at cycle 0.
  - aw/wvalid high at cycle 1, both handshakes in cycle 1.
  - bready high at cycle 2, handshake in cycle 2.
  - rsp_valid at cycle 3.
- Minimum read latency: accept at cycle 0; arvalid at cycle 1; rready at cycle 2; rsp_valid at cycle 3.
- Next command can be accepted in the cycle after the rsp handshake.
- bready and rready are low outside WRESP and RDATA respectively.
- Reset mid-transaction:
  - At the next edge all AXI valid/ready outputs go to 0 and the state returns to IDLE.
  - The pending response is discarded.
- Wait counter width: clog2(TIMEOUT_CYCLES+1), minimum 1.

## Test plan
- Write 0x0000_0001 to addr 0x0, wstrb 0xF, slave with all readies high:
  - awaddr = 0x0 and wdata = 0x1 at cycle 1.
  - rsp_valid at cycle 3 with rsp_resp = 0 and rsp_timeout = 0.
- Skewed write: wready 4 cycles after awready:
  - awvalid drops after its handshake while wvalid stays high.
  - bready rises only after the W handshake.
- Read of addr 0x4 with rvalid delayed 5 cycles, rdata = 0xDEAD_BEEF, rresp = 2'b10:
  - rsp_rdata = 0xDEADBEEF and rsp_resp = 2'b10.
- TIMEOUT_CYCLES = 8, arready held low for 20 cycles:
  - arvalid stays high throughout.
  - Response arrives after the AR/R handshakes with rsp_timeout = 1.
  - The next command clears the flag.
- Backpressure: rsp_ready low for 3 cycles:
  - rsp_* stable, cmd_ready = 0.
  - A new command is accepted the cycle after the rsp handshake.
- rst_n low for 1 cycle while in WADDR:
  - All valids are 0 at the next edge and busy = 0.
  - cmd_ready = 1 after reset releases.
